// File: rtl/dacctl_mc.sv
// SPI front end for the MCP48x1/MCP48x2 DAC family: one or two channels, 8/10/12-bit data,
// per-channel gain/shutdown, and either one trailing LDAC pulse or LDAC held low.
module dacctl_mc #(
  parameter int DATA_W    = 10,
  parameter int CH_N      = 2,
  parameter int SCK_DIV   = 2,
  parameter int LDAC_MODE = 1,
  parameter int LDAC_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_N*DATA_W-1:0] din,
  input  logic [CH_N-1:0]        dmask,
  input  logic [CH_N-1:0]        gain_x2,
  input  logic [CH_N-1:0]        shdn,
  input  logic                   dvalid,
  output logic                   dready,
  output logic                   spi_cs_n,
  output logic                   spi_sck,
  output logic                   spi_sdi,
  output logic                   spi_ldac_n,
  output logic                   busy,
  output logic                   done
);

  localparam int   CH_W      = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int   CNT_MAX   = (2 * SCK_DIV > LDAC_W) ? 2 * SCK_DIV : LDAC_W;
  localparam int   CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic LDAC_IDLE = (LDAC_MODE != 0);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, LDAC, FINISH} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [3:0]             bit_q;
  logic                   sckHigh_q;
  logic [15:0]            shift_q;
  logic [CH_N-1:0]        pend_q;
  logic [CH_N*DATA_W-1:0] din_q;
  logic [CH_N-1:0]        gain_q;
  logic [CH_N-1:0]        shdn_q;
  logic                   csN_q, sck_q, sdi_q, ldacN_q, busy_q, done_q;

  function automatic logic [CH_W-1:0] lowestSet(input logic [CH_N-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      if (m[k]) idx = CH_W'(k);
    end
    return idx;
  endfunction

  // Command word: channel select, don't-care, GA_n, SHDN_n, then left-aligned data.
  function automatic logic [15:0] makeWord(input logic [CH_W-1:0]        ch,
                                           input logic [CH_N*DATA_W-1:0] d,
                                           input logic [CH_N-1:0]        g,
                                           input logic [CH_N-1:0]        s);
    logic [15:0] w;
    w     = '0;
    w[15] = (ch != '0);
    for (int k = 0; k < CH_N; k++) begin
      if (ch == CH_W'(k)) begin
        w[13]           = ~g[k];
        w[12]           = ~s[k];
        w[11 -: DATA_W] = d[k*DATA_W +: DATA_W];
      end
    end
    return w;
  endfunction

  logic [CH_W-1:0] acceptCh, nextCh;
  logic [15:0]     acceptWord, nextWord;

  assign acceptCh   = lowestSet(dmask);
  assign nextCh     = lowestSet(pend_q);
  assign acceptWord = makeWord(acceptCh, din, gain_x2, shdn);
  assign nextWord   = makeWord(nextCh, din_q, gain_q, shdn_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sckHigh_q <= 1'b0;
      shift_q   <= '0;
      pend_q    <= '0;
      din_q     <= '0;
      gain_q    <= '0;
      shdn_q    <= '0;
      csN_q     <= 1'b1;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      ldacN_q   <= LDAC_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dvalid) begin
            din_q  <= din;
            gain_q <= gain_x2;
            shdn_q <= shdn;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (dmask == '0) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              pend_q  <= dmask & ~(CH_N'(1) << acceptCh);
              shift_q <= {acceptWord[14:0], 1'b0};
              sdi_q   <= acceptWord[15];
              csN_q   <= 1'b0;
              state_q <= LEAD;
            end
          end
        end
        LEAD: begin
          if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
            cnt_q     <= '0;
            sck_q     <= 1'b1;
            sckHigh_q <= 1'b1;
            bit_q     <= 4'd15;
            state_q   <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // bit_q is the bit currently on sdi; the last low phase doubles as CS hold.
        SHIFT: begin
          if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
            cnt_q <= '0;
            if (sckHigh_q) begin
              sck_q     <= 1'b0;
              sckHigh_q <= 1'b0;
              if (bit_q != 4'd0) begin
                sdi_q   <= shift_q[15];
                shift_q <= {shift_q[14:0], 1'b0};
              end
            end else if (bit_q == 4'd0) begin
              csN_q   <= 1'b1;
              sdi_q   <= 1'b0;
              state_q <= GAP;
            end else begin
              sck_q     <= 1'b1;
              sckHigh_q <= 1'b1;
              bit_q     <= bit_q - 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == CNT_W'(2 * SCK_DIV - 1)) begin
            cnt_q <= '0;
            if (pend_q != '0) begin
              pend_q  <= pend_q & ~(CH_N'(1) << nextCh);
              shift_q <= {nextWord[14:0], 1'b0};
              sdi_q   <= nextWord[15];
              csN_q   <= 1'b0;
              state_q <= LEAD;
            end else if (LDAC_MODE != 0) begin
              ldacN_q <= 1'b0;
              state_q <= LDAC;
            end else begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LDAC: begin
          if (cnt_q == CNT_W'(LDAC_W - 1)) begin
            cnt_q   <= '0;
            ldacN_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dready     = ~busy_q;
  assign spi_cs_n   = csN_q;
  assign spi_sck    = sck_q;
  assign spi_sdi    = sdi_q;
  assign spi_ldac_n = ldacN_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
